pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_stall_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall controller for a five-stage pipeline: tracks the EXE/MEM
// slots, resolves load-use, branch flush and memory-wait events by priority.
module pipe_stall_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_two_src,
    input  logic [3:0]  id_dest,
    input  logic        id_wb_en,
    input  logic        id_mem_r_en,
    input  logic        id_mem_w_en,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        freeze_if,
    output logic        freeze_id,
    output logic        freeze_ex,
    output logic        freeze_mem,
    output logic        bubble_ex,
    output logic        flush_id,
    output logic [3:0]  exe_dest,
    output logic        exe_mem_r_en,
    output logic [1:0]  stall_cause,
    output logic [15:0] stall_count,
    output logic        mem_timeout
);

    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
    } slot_t;

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

    slot_t      id_slot;
    slot_t      ex_slot_p1;
    slot_t      mem_slot_p2;
    state_t     state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_inc;
    logic       mem_busy;
    logic       load_use;
    logic       do_br;
    logic       do_lu;
    logic [1:0] cause;

    assign id_slot = {id_valid, id_dest, id_wb_en, id_mem_r_en, id_mem_w_en};

    assign mem_busy = mem_slot_p2.valid & (mem_slot_p2.mem_r_en | mem_slot_p2.mem_w_en) & ~mem_ready;
    assign load_use = id_valid & ex_slot_p1.valid & ex_slot_p1.mem_r_en & ex_slot_p1.wb_en &
                      ((id_src1 == ex_slot_p1.dest) | (id_two_src & (id_src2 == ex_slot_p1.dest)));

    // A branch outranks load-use: the dependent instruction is flushed anyway.
    assign do_br = ~mem_busy & branch_taken;
    assign do_lu = ~mem_busy & ~branch_taken & load_use;
    assign cause = mem_busy ? 2'd2 : (do_br ? 2'd3 : (do_lu ? 2'd1 : 2'd0));

    // Control outputs are forced low while reset is held, whatever the inputs do.
    assign freeze_if   = rst_n & (mem_busy | do_lu);
    assign freeze_id   = rst_n & (mem_busy | do_lu);
    assign freeze_ex   = rst_n & mem_busy;
    assign freeze_mem  = rst_n & mem_busy;
    assign bubble_ex   = rst_n & (do_br | do_lu);
    assign flush_id    = rst_n & do_br;
    assign stall_cause = rst_n ? cause : 2'd0;

    assign exe_dest     = ex_slot_p1.dest;
    assign exe_mem_r_en = ex_slot_p1.mem_r_en;

    assign wait_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

    // ---- EXE / MEM tracking slots ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot_p1  <= '0;
            mem_slot_p2 <= '0;
        end else if (!mem_busy) begin
            mem_slot_p2 <= ex_slot_p1;
            ex_slot_p1  <= (do_br | do_lu) ? slot_t'('0) : id_slot;
        end
    end

    // ---- memory-wait FSM and timeout ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_busy) begin
                        wait_cnt <= wait_inc;
                        if (wait_inc == TIMEOUT_CNT)
                            mem_timeout <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // ---- saturating stall counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= 16'd0;
        else if ((cause != 2'd0) && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized scoreboard bench for pipe_stall_ctrl against a behavioural
// model of the hazard rules, plus directed hazard and saturation sequences.
module tb_pipe_stall_ctrl;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_two_src, id_wb_en, id_mem_r_en, id_mem_w_en;
    logic [3:0]  id_src1, id_src2, id_dest;
    logic        branch_taken, mem_ready;
    logic        freeze_if, freeze_id, freeze_ex, freeze_mem, bubble_ex, flush_id;
    logic [3:0]  exe_dest;
    logic        exe_mem_r_en;
    logic [1:0]  stall_cause;
    logic [15:0] stall_count;
    logic        mem_timeout;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .freeze_if(freeze_if), .freeze_id(freeze_id), .freeze_ex(freeze_ex),
        .freeze_mem(freeze_mem), .bubble_ex(bubble_ex), .flush_id(flush_id),
        .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en),
        .stall_cause(stall_cause), .stall_count(stall_count), .mem_timeout(mem_timeout)
    );

    typedef struct {
        bit       rst_n;
        bit       v;
        bit [3:0] s1, s2;
        bit       two;
        bit [3:0] d;
        bit       wb, r, w;
        bit       br;
        bit       rdy;
    } stim_t;

    // Instruction record held by the model for the EXE and MEM positions.
    typedef struct {
        bit       v;
        bit [3:0] d;
        bit       wb, r, w;
    } instr_t;

    typedef logic [29:0] obs_t;

    obs_t   sbq[$];
    instr_t in_exe, in_mem;
    int     m_stalls;
    int     m_busy_run;
    bit     m_timeout;
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;

    function automatic instr_t empty_instr();
        instr_t e;
        e.v = 0; e.d = 0; e.wb = 0; e.r = 0; e.w = 0;
        return e;
    endfunction

    function automatic obs_t pack_obs(bit fif, bit fid, bit fex, bit fmem, bit bub, bit fl,
                                      bit [3:0] ed, bit er, bit [1:0] c, bit [15:0] sc, bit to);
        return {fif, fid, fex, fmem, bub, fl, ed, er, c, sc, to};
    endfunction

    task automatic model_reset();
        in_exe     = empty_instr();
        in_mem     = empty_instr();
        m_stalls   = 0;
        m_busy_run = 0;
        m_timeout  = 0;
    endtask

    // Apply stimulus just after the rising edge, predict this cycle, then advance the model.
    task automatic step(input stim_t s);
        bit       busy, hazard, fif, fid, fex, fmem, bub, fl;
        bit [1:0] c;
        instr_t   from_id;
        @(posedge clk);
        #1;
        rst_n = s.rst_n; id_valid = s.v; id_src1 = s.s1; id_src2 = s.s2;
        id_two_src = s.two; id_dest = s.d; id_wb_en = s.wb; id_mem_r_en = s.r;
        id_mem_w_en = s.w; branch_taken = s.br; mem_ready = s.rdy;
        cyc++;
        if (!s.rst_n) begin
            model_reset();
            sbq.push_back('0);
            return;
        end
        busy   = in_mem.v && (in_mem.r || in_mem.w) && !s.rdy;
        hazard = s.v && in_exe.v && in_exe.r && in_exe.wb &&
                 (s.s1 == in_exe.d || (s.two && s.s2 == in_exe.d));
        if (busy)          c = 2;
        else if (s.br)     c = 3;
        else if (hazard)   c = 1;
        else               c = 0;
        {fif, fid, fex, fmem, bub, fl} = 6'b0;
        case (c)
            2'd2: {fif, fid, fex, fmem} = 4'b1111;
            2'd3: {bub, fl} = 2'b11;
            2'd1: {fif, fid, bub} = 3'b111;
            default: ;
        endcase
        sbq.push_back(pack_obs(fif, fid, fex, fmem, bub, fl, in_exe.d, in_exe.r, c,
                               16'(m_stalls), m_timeout));
        if (c != 0 && m_stalls < 65535) m_stalls++;
        m_busy_run = busy ? m_busy_run + 1 : 0;
        if (m_busy_run >= TIMEOUT + 1) m_timeout = 1;
        if (c != 2) begin
            from_id.v = s.v; from_id.d = s.d; from_id.wb = s.wb; from_id.r = s.r; from_id.w = s.w;
            in_mem = in_exe;
            in_exe = (c == 0) ? from_id : empty_instr();
        end
    endtask

    function automatic stim_t nop(bit rdy);
        stim_t s;
        s.rst_n = 1; s.v = 0; s.s1 = 0; s.s2 = 0; s.two = 0; s.d = 0;
        s.wb = 0; s.r = 0; s.w = 0; s.br = 0; s.rdy = rdy;
        return s;
    endfunction

    function automatic stim_t load(bit [3:0] d);
        stim_t s = nop(1);
        s.v = 1; s.d = d; s.wb = 1; s.r = 1;
        return s;
    endfunction

    function automatic stim_t add(bit [3:0] s1, bit [3:0] s2, bit two, bit br);
        stim_t s = nop(1);
        s.v = 1; s.s1 = s1; s.s2 = s2; s.two = two; s.d = 5; s.wb = 1; s.br = br;
        return s;
    endfunction

    function automatic bit [3:0] pick_reg();
        return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    // Monitor: the DUT presents a result every cycle; compare at the falling edge.
    initial begin
        obs_t exp, act;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                exp = sbq.pop_front();
                act = {freeze_if, freeze_id, freeze_ex, freeze_mem, bubble_ex, flush_id,
                       exe_dest, exe_mem_r_en, stall_cause, stall_count, mem_timeout};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got=%h expected=%h (fif fid fex fmem bub flush ed er cause cnt to)",
                             cyc, act, exp);
                end
            end
        end
    end

    initial begin
        stim_t s;
        rst_n = 0; id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0; id_dest = 0;
        id_wb_en = 0; id_mem_r_en = 0; id_mem_w_en = 0; branch_taken = 0; mem_ready = 1;
        model_reset();

        // Reset with noisy inputs: all control outputs must stay low.
        for (int i = 0; i < 3; i++) begin
            s = add(4'd3, 4'd3, 1, 1); s.rst_n = 0; s.rdy = 0;
            step(s);
        end

        // Load r3 followed by a dependent ADD (held in ID while frozen).
        step(load(4'd3)); step(add(4'd3, 4'd0, 0, 0)); step(add(4'd3, 4'd0, 0, 0)); step(nop(1));
        // Second source ignored, then used.
        step(load(4'd3)); step(add(4'd4, 4'd3, 0, 0)); step(nop(1));
        step(load(4'd3)); step(add(4'd4, 4'd3, 1, 0)); step(add(4'd4, 4'd3, 1, 0)); step(nop(1));
        // Load-use coinciding with a taken branch.
        step(load(4'd3)); step(add(4'd3, 4'd0, 0, 1)); step(nop(1));
        // Register 15 dependency.
        step(load(4'd15)); step(add(4'd15, 4'd0, 0, 0)); step(add(4'd15, 4'd0, 0, 0)); step(nop(1));
        // Load reaches MEM and waits five cycles for memory.
        step(load(4'd7)); step(nop(1));
        for (int i = 0; i < 5; i++) step(nop(0));
        step(nop(1)); step(nop(1)); step(nop(1));

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            s.rst_n = ($urandom_range(0, 299) != 0);
            s.v   = ($urandom_range(0, 3) != 0);
            s.s1  = pick_reg(); s.s2 = pick_reg(); s.d = pick_reg();
            s.two = $urandom_range(0, 1);
            s.wb  = ($urandom_range(0, 3) != 0);
            s.r   = ($urandom_range(0, 2) == 0);
            s.w   = !s.r && ($urandom_range(0, 4) == 0);
            s.br  = ($urandom_range(0, 7) == 0);
            s.rdy = ($urandom_range(0, 3) != 0);
            step(s);
        end

        // Long memory wait: timeout and stall counter saturation, then reset mid-wait.
        step(nop(1)); step(nop(1)); step(load(4'd2)); step(nop(1));
        for (int i = 0; i < 65600; i++) step(nop(0));
        s = nop(0); s.rst_n = 0;
        step(s); step(s);
        for (int i = 0; i < 4; i++) step(nop(1));

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
